// File: rtl/controlador_suma_serial.sv
// controlador_suma_serial
// Adds two W-bit operands (W = 3*N_SLICES) by reusing one 3-bit adder slice,
// one slice per clock, LSB slice first, with the carry chained in a register.
// The requester side is a start/ready/busy/done handshake; sum/cout only
// change on the completion edge and hold until the next completion or reset.

module controlador_suma_serial #(
  parameter int N_SLICES = 4,
  localparam int W = 3 * N_SLICES
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic         ready,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Index counter is at least one bit wide even for a single slice.
  localparam int IDX_W = (N_SLICES > 1) ? $clog2(N_SLICES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_SLICES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SUMA = 2'b01,
    ST_FIN  = 2'b10
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_accept;
  logic             w_last;

  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_psum;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_ready;
  logic             r_busy;
  logic             r_done;

  logic [IDX_W+1:0] w_shamt;
  logic [2:0]       w_a3;
  logic [2:0]       w_b3;
  logic [3:0]       w_slice;
  logic [W-1:0]     w_mask;
  logic [W-1:0]     w_psum_next;

  assign w_last = (r_idx == LAST_IDX);

  // Slice datapath: bit offset 3*idx built as 2*idx + idx, then one 3-bit add.
  always_comb begin
    w_shamt     = {1'b0, r_idx, 1'b0} + {2'b00, r_idx};
    w_a3        = 3'(r_a >> w_shamt);
    w_b3        = 3'(r_b >> w_shamt);
    w_slice     = {1'b0, w_a3} + {1'b0, w_b3} + {3'b000, r_carry};
    w_mask      = W'(3'b111) << w_shamt;
    w_psum_next = (r_psum & ~w_mask) | (W'(w_slice[2:0]) << w_shamt);
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next-state logic and request acceptance.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_SUMA;
          w_accept     = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_SUMA: begin
        if (w_last) begin
          w_state_next = ST_FIN;
        end else begin
          w_state_next = ST_SUMA;
        end
      end
      ST_FIN: begin
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Operand latch, slice sequencing, and result publication on the last slice.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a     <= {W{1'b0}};
      r_b     <= {W{1'b0}};
      r_psum  <= {W{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
      r_carry <= 1'b0;
      r_sum   <= {W{1'b0}};
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_psum  <= {W{1'b0}};
      r_idx   <= {IDX_W{1'b0}};
      r_carry <= 1'b0;
    end else if (r_state == ST_SUMA) begin
      r_psum  <= w_psum_next;
      r_carry <= w_slice[3];
      if (w_last) begin
        r_idx  <= {IDX_W{1'b0}};
        r_sum  <= w_psum_next;
        r_cout <= w_slice[3];
      end else begin
        r_idx  <= r_idx + IDX_W'(1'b1);
      end
    end
  end

  // Handshake flags registered from the next state so they track the FSM exactly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_ready <= (w_state_next == ST_IDLE);
      r_busy  <= (w_state_next == ST_SUMA) || (w_state_next == ST_FIN);
      r_done  <= (w_state_next == ST_FIN);
    end
  end

  assign ready = r_ready;
  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign cout  = r_cout;

endmodule

// File: tb/tb_controlador_suma_serial.sv
// Bench for controlador_suma_serial: a 4-slice instance driven with directed
// and random operands, and a 1-slice instance swept exhaustively. Expected
// results come from plain W-bit addition of the operands offered at accept.

module tb_controlador_suma_serial;

  localparam int N4 = 4;

  logic        clk = 1'b0;
  logic        rst_n;

  logic        start4;
  logic [11:0] a4;
  logic [11:0] b4;
  logic        ready4;
  logic        busy4;
  logic        done4;
  logic [11:0] sum4;
  logic        cout4;

  logic        start1;
  logic [2:0]  a1;
  logic [2:0]  b1;
  logic        ready1;
  logic        busy1;
  logic        done1;
  logic [2:0]  sum1;
  logic        cout1;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [12:0] prev_res4;

  always #5 clk = ~clk;

  controlador_suma_serial #(.N_SLICES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .a(a4), .b(b4),
    .ready(ready4), .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
  );

  controlador_suma_serial #(.N_SLICES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
    .ready(ready1), .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready4();
    int k;
    k = 0;
    while (!ready4 && k < 20) begin
      tick();
      k++;
    end
    check_eq("ready_wait", 64'(ready4), 64'd1);
  endtask

  // One operation on the 4-slice DUT; optionally scramble inputs while busy.
  task automatic op4(input logic [11:0] ea, input logic [11:0] eb, input bit disturb);
    logic [12:0] exp;
    wait_ready4();
    a4     = ea;
    b4     = eb;
    start4 = 1'b1;
    exp    = {1'b0, ea} + {1'b0, eb};
    tick();
    start4 = 1'b0;
    for (int k = 1; k <= N4; k++) begin
      check_eq("busy", 64'(busy4), 64'd1);
      check_eq("done_early", 64'(done4), 64'd0);
      check_eq("held_result", 64'({cout4, sum4}), 64'(prev_res4));
      if (disturb) begin
        a4     = 12'($urandom);
        b4     = 12'($urandom);
        start4 = 1'($urandom_range(0, 1));
      end
      tick();
    end
    start4 = 1'b0;
    check_eq("done", 64'(done4), 64'd1);
    check_eq("busy_fin", 64'(busy4), 64'd1);
    check_eq("result", 64'({cout4, sum4}), 64'(exp));
    prev_res4 = exp;
    tick();
    check_eq("done_once", 64'(done4), 64'd0);
    check_eq("ready_back", 64'(ready4), 64'd1);
    check_eq("hold_after", 64'({cout4, sum4}), 64'(exp));
  endtask

  initial begin
    int          acc[$];
    int          n_done;
    bit          rb;
    logic [12:0] pend;
    int          a0;
    int          a1v;
    int          a2;

    // Reset held for two edges with start asserted.
    rst_n  = 1'b0;
    start4 = 1'b1;
    start1 = 1'b1;
    a4     = 12'hABC;
    b4     = 12'h123;
    a1     = 3'd5;
    b1     = 3'd6;
    tick();
    tick();
    check_eq("rst_ready", 64'(ready4), 64'd1);
    check_eq("rst_busy", 64'(busy4), 64'd0);
    check_eq("rst_done", 64'(done4), 64'd0);
    check_eq("rst_sum", 64'(sum4), 64'h000);
    check_eq("rst_cout", 64'(cout4), 64'd0);
    prev_res4 = 13'h0000;
    rst_n  = 1'b1;
    start4 = 1'b0;
    start1 = 1'b0;
    tick();
    check_eq("idle_after_rst", 64'(busy4), 64'd0);

    // Directed arithmetic boundaries.
    op4(12'hFFF, 12'h001, 1'b0);
    op4(12'h5A3, 12'h21C, 1'b0);
    op4(12'h800, 12'h800, 1'b0);

    // Inputs and start toggled while busy must not disturb the result.
    for (int i = 0; i < 4; i++) begin
      op4(12'($urandom), 12'($urandom), 1'b1);
    end

    // Start held high: accepts every N_SLICES+2 edges, operands change every cycle.
    wait_ready4();
    start4 = 1'b1;
    n_done = 0;
    pend   = 13'h0000;
    for (int e = 0; e <= 16; e++) begin
      rb = ready4;
      if (rb) begin
        pend = {1'b0, a4} + {1'b0, b4};
      end
      tick();
      if (rb) begin
        acc.push_back(e);
      end
      if (done4) begin
        n_done++;
        check_eq("stream_result", 64'({cout4, sum4}), 64'(pend));
      end
      a4 = 12'($urandom);
      b4 = 12'($urandom);
    end
    start4 = 1'b0;
    tick();
    prev_res4 = pend;
    a0  = (acc.size() > 0) ? acc[0] : -1;
    a1v = (acc.size() > 1) ? acc[1] : -1;
    a2  = (acc.size() > 2) ? acc[2] : -1;
    check_eq("accept_count", 64'(acc.size()), 64'd3);
    check_eq("accept_e0", 64'(a0), 64'd0);
    check_eq("accept_e1", 64'(a1v), 64'd6);
    check_eq("accept_e2", 64'(a2), 64'd12);
    check_eq("stream_dones", 64'(n_done), 64'd3);

    // Reset at edge 2 of an operation aborts it without a done pulse.
    wait_ready4();
    a4     = 12'h321;
    b4     = 12'h456;
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_eq("abort_ready", 64'(ready4), 64'd1);
    check_eq("abort_busy", 64'(busy4), 64'd0);
    check_eq("abort_done", 64'(done4), 64'd0);
    check_eq("abort_res", 64'({cout4, sum4}), 64'd0);
    n_done = 0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (done4) begin
        n_done++;
      end
    end
    check_eq("abort_no_done", 64'(n_done), 64'd0);
    prev_res4 = 13'h0000;
    op4(12'h777, 12'h889, 1'b0);

    // Random operations against plain addition.
    for (int i = 0; i < 12; i++) begin
      op4(12'($urandom), 12'($urandom), 1'b0);
    end

    // Single-slice instance: exhaustive 3-bit sweep.
    for (int x = 0; x < 8; x++) begin
      for (int y = 0; y < 8; y++) begin
        check_eq("n1_ready", 64'(ready1), 64'd1);
        a1     = 3'(x);
        b1     = 3'(y);
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        check_eq("n1_busy", 64'(busy1), 64'd1);
        check_eq("n1_done_early", 64'(done1), 64'd0);
        tick();
        check_eq("n1_done", 64'(done1), 64'd1);
        check_eq("n1_sum", 64'({cout1, sum1}), 64'(x + y));
        tick();
        check_eq("n1_done_once", 64'(done1), 64'd0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
